// File: rtl/otn_frame_aligner.sv
//==============================================================================
// Module : otn_frame_aligner
// Brief  : Serial OTN FAS hunt/presync/sync aligner forwarding payload bytes.
//          Optional macro OTN_FAS_ERR_CNT_EN adds the o_fas_err_cnt output.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module otn_frame_aligner #(
  parameter logic [15:0] FAS_PATTERN = 16'hF628,
  parameter int          FRAME_BYTES = 64,
  parameter int          LOCK_CNT    = 2,
  parameter int          UNLOCK_CNT  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bit,
  input  logic        i_bit_valid,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic        o_locked,
  output logic        o_oof
`ifdef OTN_FAS_ERR_CNT_EN
  ,
  output logic [15:0] o_fas_err_cnt
`endif
);

  localparam int                c_FRAME_BITS = FRAME_BYTES * 8;
  localparam int                c_CW         = $clog2(c_FRAME_BITS);
  localparam logic [c_CW-1:0]   c_LAST       = c_CW'(c_FRAME_BITS - 1);
  localparam logic [c_CW-1:0]   c_DATA_END   = c_CW'(c_FRAME_BITS - 16);
  localparam logic [c_CW-1:0]   c_FIRST_BYTE = c_CW'(7);
  localparam logic [2:0]        c_LOCK       = 3'(LOCK_CNT);
  localparam logic [2:0]        c_UNLOCK     = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_SYNC    = 2'd2
  } state_t;

  state_t            r_state;
  // The incoming bit completes the 16-bit window, so only 15 history bits are stored.
  logic [14:0]       r_sr;
  logic [c_CW-1:0]   r_cnt;
  logic [2:0]        r_good;
  logic [2:0]        r_bad;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_fas;
  logic              r_locked;
  logic              r_oof;

  logic [15:0]       w_sr_next;
  logic              w_match;
  logic              w_wrap;
  logic [c_CW-1:0]   w_cnt_next;
  logic              w_byte_done;
  logic              w_first_byte;
  logic [2:0]        w_good_inc;
  logic [2:0]        w_bad_inc;

  assign w_sr_next    = {r_sr, i_bit};
  assign w_match      = (w_sr_next == FAS_PATTERN);
  assign w_wrap       = (r_cnt == c_LAST);
  assign w_cnt_next   = w_wrap ? '0 : r_cnt + 1'b1;
  // Payload bytes end below the FAS region; the two FAS bytes never qualify.
  assign w_byte_done  = (r_cnt[2:0] == 3'b111) && (r_cnt < c_DATA_END);
  assign w_first_byte = (r_cnt == c_FIRST_BYTE);
  assign w_good_inc   = r_good + 3'd1;
  assign w_bad_inc    = r_bad + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_HUNT;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_fas    <= 1'b0;
      r_locked <= 1'b0;
      r_oof    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fas   <= 1'b0;
      r_oof   <= 1'b0;
      if (i_bit_valid) begin
        r_sr  <= w_sr_next[14:0];
        r_cnt <= w_cnt_next;
        if (r_state == ST_SYNC && w_byte_done) begin
          r_data  <= w_sr_next[7:0];
          r_valid <= 1'b1;
          r_fas   <= w_first_byte;
        end
        case (r_state)
          ST_HUNT: begin
            if (w_match) begin
              r_cnt  <= '0;
              r_good <= 3'd1;
              r_bad  <= '0;
              if (LOCK_CNT == 1) begin
                r_state  <= ST_SYNC;
                r_locked <= 1'b1;
              end else begin
                r_state <= ST_PRESYNC;
              end
            end
          end
          ST_PRESYNC: begin
            if (w_wrap) begin
              if (w_match) begin
                r_good <= w_good_inc;
                if (w_good_inc >= c_LOCK) begin
                  r_state  <= ST_SYNC;
                  r_locked <= 1'b1;
                end
              end else begin
                r_state <= ST_HUNT;
              end
            end
          end
          ST_SYNC: begin
            if (w_wrap) begin
              if (w_match) begin
                r_bad <= '0;
              end else if (w_bad_inc >= c_UNLOCK) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_oof    <= 1'b1;
                r_bad    <= '0;
              end else begin
                r_bad <= w_bad_inc;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_fas;
  assign o_locked           = r_locked;
  assign o_oof              = r_oof;

`ifdef OTN_FAS_ERR_CNT_EN
  logic [15:0] r_fas_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fas_err_cnt <= '0;
    end else if (i_bit_valid && r_state == ST_SYNC && w_wrap && !w_match &&
                 r_fas_err_cnt != 16'hFFFF) begin
      r_fas_err_cnt <= r_fas_err_cnt + 16'd1;
    end
  end

  assign o_fas_err_cnt = r_fas_err_cnt;
`else
  // No FAS mismatch counter in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_otn_frame_aligner.sv
//==============================================================================
// Module : tb_otn_frame_aligner
// Brief  : Randomised bench for otn_frame_aligner against a bit-level frame model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_otn_frame_aligner;

  localparam int          FB     = 8;
  localparam int          FBITS  = FB * 8;
  localparam logic [15:0] FAS    = 16'hF628;
  localparam logic [15:0] BADFAS = 16'h0000;
  localparam int          LOCK   = 2;
  localparam int          UNLOCK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_bit;
  logic        i_bit_valid;
  logic [7:0]  o_frame_data;
  logic        o_frame_data_valid;
  logic        o_frame_data_fas;
  logic        o_locked;
  logic        o_oof;
`ifdef OTN_FAS_ERR_CNT_EN
  logic [15:0] o_fas_err_cnt;
`endif

  otn_frame_aligner #(
    .FAS_PATTERN (FAS),
    .FRAME_BYTES (FB),
    .LOCK_CNT    (LOCK),
    .UNLOCK_CNT  (UNLOCK)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_bit              (i_bit),
    .i_bit_valid        (i_bit_valid),
    .o_frame_data       (o_frame_data),
    .o_frame_data_valid (o_frame_data_valid),
    .o_frame_data_fas   (o_frame_data_fas),
    .o_locked           (o_locked),
    .o_oof              (o_oof)
`ifdef OTN_FAS_ERR_CNT_EN
    ,
    .o_fas_err_cnt      (o_fas_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       stim[$];
  logic [7:0] got[$];
  int         n_fas, n_oof, n_drop, n_lock_cyc;
  logic       prev_locked;

  // Reference model: window value, accepted bits since last FAS end, state 0/1/2.
  int         m_win, m_since, m_st, m_good, m_bad, m_err;
  logic [7:0] exp_data;
  logic       exp_valid, exp_fas, exp_locked, exp_oof;

  logic [11:0] obs;
  logic [11:0] expv;
  assign obs  = {o_frame_data_valid, o_frame_data_fas, o_frame_data, o_locked, o_oof};
  assign expv = {exp_valid, exp_fas, exp_data, exp_locked, exp_oof};

  always @(negedge clk) begin
    if (o_frame_data_valid === 1'b1) begin
      got.push_back(o_frame_data);
      if (o_frame_data_fas === 1'b1) n_fas++;
    end
    if (o_oof === 1'b1) n_oof++;
    if (o_locked === 1'b1) n_lock_cyc++;
    if (prev_locked === 1'b1 && o_locked === 1'b0) n_drop++;
    prev_locked = o_locked;
  end

  task automatic model_reset();
    m_win = 0; m_since = 0; m_st = 0; m_good = 0; m_bad = 0; m_err = 0;
    exp_data = 8'h00; exp_valid = 1'b0; exp_fas = 1'b0; exp_locked = 1'b0; exp_oof = 1'b0;
  endtask

  task automatic model_bit(input logic b, input logic v);
    logic match;
    exp_valid = 1'b0; exp_fas = 1'b0; exp_oof = 1'b0;
    if (v) begin
      m_win   = ((m_win << 1) | int'(b)) & 32'hFFFF;
      m_since = m_since + 1;
      match   = (m_win == int'(FAS));
      if (m_st == 2 && (m_since % 8) == 0 && m_since <= FBITS - 16) begin
        exp_data  = 8'(m_win & 255);
        exp_valid = 1'b1;
        exp_fas   = (m_since == 8);
      end
      if (m_st == 0) begin
        if (match) begin
          m_since = 0; m_good = 1; m_bad = 0;
          m_st = (LOCK == 1) ? 2 : 1;
        end
      end else if (m_since == FBITS) begin
        m_since = 0;
        if (m_st == 1) begin
          if (match) begin
            m_good = m_good + 1;
            if (m_good >= LOCK) m_st = 2;
          end else begin
            m_st = 0;
          end
        end else if (match) begin
          m_bad = 0;
        end else begin
          m_bad = m_bad + 1;
          if (m_err < 65535) m_err = m_err + 1;
          if (m_bad >= UNLOCK) begin
            m_st = 0; m_bad = 0; exp_oof = 1'b1;
          end
        end
      end
      exp_locked = (m_st == 2);
    end
  endtask

  task automatic drive(input logic b, input logic v);
    i_bit = b; i_bit_valid = v;
    model_bit(b, v);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_bits(input logic [15:0] val, input int n);
    for (int k = n - 1; k >= 0; k--) stim.push_back(val[k]);
  endtask

  // mode 0: bytes 1..FB-2, mode 1: constant fill, mode 2: random bytes.
  task automatic push_frame(input logic [15:0] fas, input int mode, input logic [7:0] fill);
    push_bits(fas, 16);
    for (int k = 0; k < FB - 2; k++) begin
      if (mode == 0)      push_bits(16'(k + 1), 8);
      else if (mode == 1) push_bits({8'h00, fill}, 8);
      else                push_bits(16'($urandom_range(255)), 8);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0;
    model_reset();
    stim.delete();
    repeat (2) @(negedge clk);
    #1;
    got.delete(); n_fas = 0; n_oof = 0; n_drop = 0; n_lock_cyc = 0; prev_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      i_bit = 1'b1; i_bit_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs k=%0d got=%h exp=000", k, obs); end
    end
`ifdef OTN_FAS_ERR_CNT_EN
    checks++;
    if (o_fas_err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_errcnt got=%h exp=0000", o_fas_err_cnt); end
`endif
    i_bit_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_release got=%h exp=000", obs); end
  endtask

  task automatic test_lock();
    logic v;
    int   lock_at;
    do_reset();
    lock_at = -1;
    for (int f = 0; f < 3; f++) push_frame(FAS, 0, 8'h00);
    foreach (stim[i]) begin
      v = 1'b1;
      drive(stim[i], v);
      if (o_locked === 1'b1 && lock_at < 0) lock_at = i;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL lock_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    #1;
    checks++;
    if (lock_at != 79) begin errors++; $display("FAIL lock_time got=%0d exp=79", lock_at); end
    checks++;
    if (got.size() != 12 || n_fas != 2) begin
      errors++; $display("FAIL lock_count got=%0d/%0d exp=12/2", got.size(), n_fas);
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (got[k] !== 8'((k % 6) + 1)) begin
          errors++; $display("FAIL lock_byte k=%0d got=%h exp=%h", k, got[k], 8'((k % 6) + 1));
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic v;
    do_reset();
    push_bits(16'($urandom_range(31)), 5);
    for (int f = 0; f < 3; f++) push_frame(FAS, 0, 8'h00);
    foreach (stim[i]) begin
      do begin
        v = ($urandom_range(99) < 50);
        drive(v ? stim[i] : 1'($urandom_range(1)), v);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL gapped_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end while (!v);
    end
    #1;
    checks++;
    if (got.size() != 12 || got[0] !== 8'h01 || got[11] !== 8'h06) begin
      errors++; $display("FAIL gapped_bytes got=%0d exp=12", got.size());
    end
  endtask

  task automatic test_flywheel();
    logic v;
    do_reset();
    push_frame(FAS, 2, 8'h00);
    push_frame(FAS, 2, 8'h00);
    push_frame(BADFAS, 2, 8'h00);
    push_frame(BADFAS, 2, 8'h00);
    push_frame(FAS, 2, 8'h00);
    push_frame(FAS, 2, 8'h00);
    foreach (stim[i]) begin
      do begin
        v = ($urandom_range(99) < 80);
        drive(v ? stim[i] : 1'($urandom_range(1)), v);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL flywheel_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end while (!v);
    end
    #1;
    checks++;
    if (got.size() != 30 || n_drop != 0 || o_locked !== 1'b1) begin
      errors++; $display("FAIL flywheel_summary got=%0d/%0d/%b exp=30/0/1", got.size(), n_drop, o_locked);
    end
`ifdef OTN_FAS_ERR_CNT_EN
    checks++;
    if (o_fas_err_cnt !== 16'd2) begin errors++; $display("FAIL flywheel_errcnt got=%0d exp=2", o_fas_err_cnt); end
`endif
  endtask

  task automatic test_unlock();
    logic v;
    do_reset();
    push_frame(FAS, 2, 8'h00);
    push_frame(FAS, 2, 8'h00);
    push_frame(BADFAS, 2, 8'h00);
    push_frame(BADFAS, 2, 8'h00);
    push_frame(BADFAS, 1, 8'h55);
    push_frame(BADFAS, 1, 8'h55);
    foreach (stim[i]) begin
      do begin
        v = ($urandom_range(99) < 70);
        drive(v ? stim[i] : 1'($urandom_range(1)), v);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL unlock_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end while (!v);
    end
    #1;
    checks++;
    if (n_oof != 1 || n_drop != 1 || got.size() != 18 || o_locked !== 1'b0) begin
      errors++; $display("FAIL unlock_summary got=%0d/%0d/%0d exp=1/1/18", n_oof, n_drop, got.size());
    end
`ifdef OTN_FAS_ERR_CNT_EN
    checks++;
    if (o_fas_err_cnt !== 16'd3) begin errors++; $display("FAIL unlock_errcnt got=%0d exp=3", o_fas_err_cnt); end
`endif
  endtask

  task automatic test_presync_fail();
    logic v;
    do_reset();
    push_frame(FAS, 2, 8'h00);
    push_frame(BADFAS, 1, 8'h55);
    push_frame(BADFAS, 1, 8'h55);
    foreach (stim[i]) begin
      do begin
        v = ($urandom_range(99) < 60);
        drive(v ? stim[i] : 1'($urandom_range(1)), v);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL presync_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end while (!v);
    end
    #1;
    checks++;
    if (n_lock_cyc != 0 || got.size() != 0) begin
      errors++; $display("FAIL presync_summary got=%0d/%0d exp=0/0", n_lock_cyc, got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic v;
    int   lock_at;
    do_reset();
    push_frame(FAS, 2, 8'h00);
    push_frame(FAS, 2, 8'h00);
    push_bits(FAS, 16);
    push_bits(16'h00A5, 8);
    push_bits(16'h00A5, 8);
    push_bits(16'h0003, 4);
    foreach (stim[i]) begin
      v = 1'b1;
      drive(stim[i], v);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL midrst_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    checks++;
    if (o_locked !== 1'b1 || o_frame_data !== 8'hA5) begin
      errors++; $display("FAIL midrst_pre got=%b/%h exp=1/a5", o_locked, o_frame_data);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL midrst_async got=%h exp=000", obs); end
    i_bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got.delete(); n_fas = 0; n_oof = 0; n_drop = 0; n_lock_cyc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    stim.delete();
    lock_at = -1;
    for (int f = 0; f < 3; f++) push_frame(FAS, 0, 8'h00);
    foreach (stim[i]) begin
      v = 1'b1;
      drive(stim[i], v);
      if (o_locked === 1'b1 && lock_at < 0) lock_at = i;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL relock_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    #1;
    checks++;
    if (lock_at != 79 || got.size() != 12) begin
      errors++; $display("FAIL relock_summary got=%0d/%0d exp=79/12", lock_at, got.size());
    end
  endtask

  task automatic test_random();
    logic v;
    int   pct;
    do_reset();
    pct = int'($urandom_range(100, 40));
    push_bits(16'($urandom_range(31)), 5);
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(99) < 75) push_frame(FAS, 2, 8'h00);
      else                         push_frame(16'($urandom_range(65535)), 2, 8'h00);
    end
    foreach (stim[i]) begin
      do begin
        v = ($urandom_range(99) < pct);
        drive(v ? stim[i] : 1'($urandom_range(1)), v);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL random_stream cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      end while (!v);
    end
`ifdef OTN_FAS_ERR_CNT_EN
    checks++;
    if (o_fas_err_cnt !== 16'(m_err)) begin
      errors++; $display("FAIL random_errcnt got=%0d exp=%0d", o_fas_err_cnt, m_err);
    end
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0;
    prev_locked = 1'b0;
    n_fas = 0; n_oof = 0; n_drop = 0; n_lock_cyc = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_lock();
    test_gapped();
    test_flywheel();
    test_unlock();
    test_presync_fail();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/otn_frame_aligner.md
OTN_FRAME_ALIGNER -- requirements
Module: otn_frame_aligner

Interface
REQ-001 Parameter FAS_PATTERN, default 16'hF628: frame alignment signal, sent MSB first.
REQ-002 Parameter FRAME_BYTES, default 64: frame length in bytes, including the 2 FAS bytes; legal range 4..1024.
REQ-003 Parameter LOCK_CNT, default 2: consecutive good FAS, counting the hunt match, needed to enter SYNC; legal range 1..7.
REQ-004 Parameter UNLOCK_CNT, default 3: consecutive bad FAS needed to leave SYNC; legal range 1..7.
REQ-005 Port: i_clk  in  1  the single clock; all logic is on the rising edge.
REQ-006 Port: i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port: i_bit  in  1  serial line bit from the serial receiver.
REQ-008 Port: i_bit_valid  in  1  qualifies i_bit; one bit is accepted per cycle when high.
REQ-009 Port: o_frame_data  out  8  aligned byte to the demapper; MSB is the first-received bit.
REQ-010 Port: o_frame_data_valid  out  1  one-cycle pulse per forwarded byte.
REQ-011 Port: o_frame_data_fas  out  1  high with valid on the first byte after the FAS of each forwarded frame.
REQ-012 Port: o_locked  out  1  high while in the SYNC state.
REQ-013 Port: o_oof  out  1  one-cycle pulse on the SYNC->HUNT transition (out of frame).

Function
REQ-014 Accepted bits SHALL shift MSB-first into a 16-bit register; cycles with i_bit_valid low SHALL change no state.
REQ-015 States SHALL be HUNT, PRESYNC and SYNC; a bit counter SHALL run 0..FRAME_BYTES*8-1 and wrap to 0.
REQ-016 HUNT: on the accepted bit after which the shift register equals FAS_PATTERN, the block SHALL zero the bit counter and set good count to 1.
REQ-017 HUNT match, continued: if LOCK_CNT is 1 the block SHALL go to SYNC, otherwise to PRESYNC.
REQ-018 The expected FAS position SHALL be the accepted bit that makes the bit counter wrap, i.e. exactly FRAME_BYTES*8 bits after the previous FAS end.
REQ-019 PRESYNC, at the expected position: on match, good count SHALL increment and go to SYNC on reaching LOCK_CNT; on mismatch, the block SHALL go to HUNT.
REQ-020 SYNC, at the expected position: on match, bad count SHALL clear; on mismatch, bad count SHALL increment.
REQ-021 SYNC, bad count reaching UNLOCK_CNT: go to HUNT and pulse o_oof for one cycle.
REQ-022 SYNC, bad FAS below UNLOCK_CNT: the frame SHALL still be forwarded (flywheel).
REQ-023 Bytes SHALL be forwarded only in SYNC, including the frame whose FAS caused entry to SYNC; PRESYNC and HUNT forward nothing.
REQ-024 Each forwarded frame SHALL output FRAME_BYTES-2 bytes; the FAS bytes are never forwarded.
REQ-025 A byte is complete when bit counter mod 8 == 7; it SHALL appear on o_frame_data with valid exactly 1 cycle after its 8th bit is accepted.
REQ-026 o_frame_data SHALL hold its last value between valid pulses; valid and fas SHALL be low in every other cycle.
REQ-027 A SYNC->HUNT exit coincident with a FAS position SHALL emit no byte for that frame; any byte completing in that same cycle SHALL be suppressed.
REQ-028 There is no backpressure: the downstream stage SHALL accept every valid byte.

Reset
REQ-029 On i_rst_n low, the block SHALL asynchronously enter HUNT and clear the shift register, bit counter and good/bad counts.
REQ-030 On i_rst_n low, o_frame_data SHALL be 8'h00, and o_frame_data_valid, o_frame_data_fas, o_locked and o_oof SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further output; after release, hunting SHALL restart from an empty shift register.

Configuration
REQ-032 With macro OTN_FAS_ERR_CNT_EN defined, output o_fas_err_cnt [15:0] SHALL exist; it counts FAS mismatches in SYNC, saturates at 16'hFFFF and resets to 0.
REQ-033 Without OTN_FAS_ERR_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Scenario: FRAME_BYTES=8, LOCK_CNT=2, 3 clean frames with bytes 01..06 after FAS -> o_locked rises at the 2nd FAS end; frames 2-3 emit 01..06 with fas on 01; frame 1 emits nothing.
REQ-035 Scenario: 5 random bits, then clean frames with i_bit_valid toggling 50% -> same byte sequence; each valid pulse is 1 cycle after its 8th valid bit.
REQ-036 Scenario: locked, UNLOCK_CNT=3, 2 corrupted FAS (16'h0000) then a good one -> o_locked stays 1; all frames forwarded; o_fas_err_cnt=2 with the macro defined.
REQ-037 Scenario: locked, 3 consecutive corrupted FAS -> o_oof pulses once at the 3rd; o_locked falls; no bytes from that frame on.
REQ-038 Scenario: PRESYNC with a bad 2nd FAS -> return to HUNT; o_locked never rises.
REQ-039 Scenario: i_rst_n low mid-frame while locked -> all outputs 0 immediately; relock takes LOCK_CNT frames after release.
